id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register for the 5-stage RISC-V core; the stage directly upstream of the EX forwarding muxes.
//  Latches decoded operands/controls; drives the 2-bit forward selects for ALU operands A and B.
//  Detects load-use hazards and inserts bubbles. Holds on memory stall; kills the ID instruction on flush.
//  Counts inserted bubbles for performance debug.
// PARAMETERS
//  DATA_W   32  operand/immediate width
//  CTRL_W   8   packed EX/MEM/WB control bundle width (bit map in pipeline_pkg)
//  CNT_W    16  bubble counter width
// PORTS
//  clk_i              in   1       clock, all state on rising edge
//  rst_i              in   1       synchronous reset, active-high
//  id_valid_i         in   1       ID holds a real instruction
//  id_rs1_data_i      in   DATA_W  register-file read data, rs1
//  id_rs2_data_i      in   DATA_W  register-file read data, rs2
//  id_imm_i           in   DATA_W  sign-extended immediate
//  id_rs1_addr_i      in   5       rs1 index
//  id_rs2_addr_i      in   5       rs2 index
//  id_rd_addr_i       in   5       rd index
//  id_ctrl_i          in   CTRL_W  control bundle (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], spare)
//  stall_i            in   1       data-memory/cache stall: freeze this stage
//  flush_i            in   1       kill the ID instruction (taken branch)
//  exmem_regwrite_i   in   1       EX/MEM writes a register
//  exmem_rd_i         in   5       EX/MEM destination
//  memwb_regwrite_i   in   1       MEM/WB writes a register
//  memwb_rd_i         in   5       MEM/WB destination
//  ex_valid_o         out  1       EX holds a real instruction
//  ex_rs1_data_o      out  DATA_W  latched rs1 data (forward mux input 00)
//  ex_rs2_data_o      out  DATA_W  latched rs2 data
//  ex_imm_o           out  DATA_W  latched immediate
//  ex_rs1_addr_o      out  5       latched rs1 index
//  ex_rs2_addr_o      out  5       latched rs2 index
//  ex_rd_addr_o       out  5       latched rd index
//  ex_ctrl_o          out  CTRL_W  latched controls; all-zero for a bubble
//  fwd_a_sel_o        out  2       operand A select: 00 reg, 01 MEM/WB, 10 EX/MEM
//  fwd_b_sel_o        out  2       operand B select, same encoding
//  load_use_stall_o   out  1       hold PC and IF/ID this cycle
//  bubble_cnt_o       out  CNT_W   bubbles inserted since reset, saturating
// BEHAVIOUR
//  Reset: all registered outputs 0 (valid, data, imm, addrs, ctrl, bubble_cnt); fwd selects 00; load_use_stall_o 0.
//  Latency: one cycle ID->EX. Per-edge priority: rst_i > stall_i (hold all) > flush_i (bubble) > load-use (bubble) > load.
//  Bubble: ex_valid_o=0, ex_ctrl_o=0, ex_rd_addr_o=0; data fields don't-care but driven 0.
//  load_use_stall_o (comb) = ex_valid_o & ex_ctrl_o.MemRead & ex_rd_addr_o!=0
//    & id_valid_i & (ex_rd_addr_o==id_rs1_addr_i | ex_rd_addr_o==id_rs2_addr_i); forced 0 while flush_i.
//  Forwarding (comb, on latched rs addresses), per operand X:
//    10 if exmem_regwrite_i & exmem_rd_i!=0 & exmem_rd_i==ex_rsX_addr_o;
//    else 01 if memwb_regwrite_i & memwb_rd_i!=0 & memwb_rd_i==ex_rsX_addr_o; else 00.
//    EX/MEM beats MEM/WB when both match. 11 never driven. Selects are 00 when ex_valid_o=0.
//  x0 never forwarded. Forward selects stay valid while stall_i holds; they track the EX/MEM and MEM/WB inputs.
//  bubble_cnt_o +1 on each edge a bubble is loaded by flush or load-use (not by stall or reset); holds at all-ones.
//  flush_i with load-use in the same cycle: one bubble, counted once.
//  id_valid_i=0 and no flush: loads a bubble; not counted.
//  Reset mid-stall or mid-hazard: state clears next edge; stall_i is ignored that edge.
// STRUCTURE
//  pipeline_pkg: CTRL_* bit indices, FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, REG_X0=5'd0.
//  Sub-module forward_unit (comb, two instances or dual-output): rs addr + EX/MEM/MEM/WB info -> 2-bit select.
//  Register, hazard logic and counter stay in this module.
// TESTING
//  1) rst_i=1 for 2 cycles with id inputs toggling -> all outputs 0, bubble_cnt_o=0.
//  2) EX: rs1=5; exmem_regwrite=1, rd=5; memwb_regwrite=1, rd=5 -> fwd_a=10.
//     Then exmem_rd=6 -> fwd_a=01. With rd=0 in both -> fwd_a=00.
//  3) EX lw x7 (MemRead, rd=7); ID add rs2=7 -> load_use_stall_o=1.
//     Next edge: ex_valid_o=0, ex_ctrl_o=0, bubble_cnt_o=1. Next edge: add latched, fwd_b=01 with memwb_rd=7.
//  4) stall_i=1 for 3 cycles with changing id inputs -> every ex_* output unchanged, bubble_cnt_o unchanged.
//  5) flush_i=1 with load-use also true -> single bubble, load_use_stall_o=0, bubble_cnt_o +1 only.
//  6) CNT_W=2: force 5 bubbles -> bubble_cnt_o sticks at 3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle bit map, forward-select encoding, x0 index.
package pipeline_pkg;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_MEMWRITE = 3;
  localparam int unsigned CTRL_ALUSRC   = 4;
  localparam int unsigned CTRL_ALUOP_LO = 5;
  localparam int unsigned CTRL_ALUOP_HI = 6;
  localparam int unsigned CTRL_SPARE    = 7;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/forward_unit.sv
// Operand forward select for one EX source register; EX/MEM result wins over MEM/WB.
module forward_unit
  import pipeline_pkg::*;
(
  input  logic       ex_valid,
  input  logic [4:0] rs_addr,
  input  logic       exmem_regwrite,
  input  logic [4:0] exmem_rd,
  input  logic       memwb_regwrite,
  input  logic [4:0] memwb_rd,
  output logic [1:0] sel
);

  fwd_sel_e sel_e;

  always_comb begin
    sel_e = FWD_REG;
    if (ex_valid) begin
      if (exmem_regwrite && (exmem_rd != REG_X0) && (exmem_rd == rs_addr))
        sel_e = FWD_MEM;
      else if (memwb_regwrite && (memwb_rd != REG_X0) && (memwb_rd == rs_addr))
        sel_e = FWD_WB;
    end
  end

  assign sel = sel_e;

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion, forward selects and a bubble counter.
module id_ex_operand_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs1_data_i,
  input  logic [DATA_W-1:0] id_rs2_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              exmem_regwrite_i,
  input  logic [4:0]        exmem_rd_i,
  input  logic              memwb_regwrite_i,
  input  logic [4:0]        memwb_rd_i,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_rs1_data_o,
  output logic [DATA_W-1:0] ex_rs2_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [4:0]        ex_rs1_addr_o,
  output logic [4:0]        ex_rs2_addr_o,
  output logic [4:0]        ex_rd_addr_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              load_use_stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic load_use_hazard;

  always_comb begin
    load_use_hazard = ex_valid_o && ex_ctrl_o[CTRL_MEMREAD] && (ex_rd_addr_o != REG_X0)
                      && id_valid_i
                      && ((ex_rd_addr_o == id_rs1_addr_i) || (ex_rd_addr_o == id_rs2_addr_i));
  end

  // The flush already kills the ID instruction, so the hazard needs no PC hold then.
  assign load_use_stall_o = load_use_hazard && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_rd_addr_o  <= '0;
      ex_ctrl_o     <= '0;
      bubble_cnt_o  <= '0;
    end else if (!stall_i) begin
      if (flush_i || load_use_hazard || !id_valid_i) begin
        ex_valid_o    <= 1'b0;
        ex_rs1_data_o <= '0;
        ex_rs2_data_o <= '0;
        ex_imm_o      <= '0;
        ex_rs1_addr_o <= '0;
        ex_rs2_addr_o <= '0;
        ex_rd_addr_o  <= '0;
        ex_ctrl_o     <= '0;
        // Only flush/load-use bubbles are counted; an idle ID slot is not.
        if ((flush_i || load_use_hazard) && (bubble_cnt_o != '1))
          bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end else begin
        ex_valid_o    <= 1'b1;
        ex_rs1_data_o <= id_rs1_data_i;
        ex_rs2_data_o <= id_rs2_data_i;
        ex_imm_o      <= id_imm_i;
        ex_rs1_addr_o <= id_rs1_addr_i;
        ex_rs2_addr_o <= id_rs2_addr_i;
        ex_rd_addr_o  <= id_rd_addr_i;
        ex_ctrl_o     <= id_ctrl_i;
      end
    end
  end

  forward_unit u_fwd_a (
    .ex_valid       (ex_valid_o),
    .rs_addr        (ex_rs1_addr_o),
    .exmem_regwrite (exmem_regwrite_i),
    .exmem_rd       (exmem_rd_i),
    .memwb_regwrite (memwb_regwrite_i),
    .memwb_rd       (memwb_rd_i),
    .sel            (fwd_a_sel_o)
  );

  forward_unit u_fwd_b (
    .ex_valid       (ex_valid_o),
    .rs_addr        (ex_rs2_addr_o),
    .exmem_regwrite (exmem_regwrite_i),
    .exmem_rd       (exmem_rd_i),
    .memwb_regwrite (memwb_regwrite_i),
    .memwb_rd       (memwb_rd_i),
    .sel            (fwd_b_sel_o)
  );

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares each cycle.
module tb_id_ex_operand_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] rs1_d, rs2_d, imm;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic [7:0]  ctrl;
  logic        exmem_we, memwb_we;
  logic [4:0]  exmem_rd, memwb_rd;

  logic        ex_valid, lus, ex_valid2, lus2;
  logic [31:0] ex_rs1_d, ex_rs2_d, ex_imm, ex_rs1_d2, ex_rs2_d2, ex_imm2;
  logic [4:0]  ex_rs1_a, ex_rs2_a, ex_rd, ex_rs1_a2, ex_rs2_a2, ex_rd2;
  logic [7:0]  ex_ctrl, ex_ctrl2;
  logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs1_data_i(rs1_d), .id_rs2_data_i(rs2_d), .id_imm_i(imm),
    .id_rs1_addr_i(rs1_a), .id_rs2_addr_i(rs2_a), .id_rd_addr_i(rd_a), .id_ctrl_i(ctrl),
    .stall_i(stall), .flush_i(flush),
    .exmem_regwrite_i(exmem_we), .exmem_rd_i(exmem_rd),
    .memwb_regwrite_i(memwb_we), .memwb_rd_i(memwb_rd),
    .ex_valid_o(ex_valid), .ex_rs1_data_o(ex_rs1_d), .ex_rs2_data_o(ex_rs2_d), .ex_imm_o(ex_imm),
    .ex_rs1_addr_o(ex_rs1_a), .ex_rs2_addr_o(ex_rs2_a), .ex_rd_addr_o(ex_rd), .ex_ctrl_o(ex_ctrl),
    .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b), .load_use_stall_o(lus), .bubble_cnt_o(cnt16)
  );

  // Narrow-counter copy sharing the same stimulus, used to observe saturation.
  id_ex_operand_stage #(.DATA_W(32), .CTRL_W(8), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs1_data_i(rs1_d), .id_rs2_data_i(rs2_d), .id_imm_i(imm),
    .id_rs1_addr_i(rs1_a), .id_rs2_addr_i(rs2_a), .id_rd_addr_i(rd_a), .id_ctrl_i(ctrl),
    .stall_i(stall), .flush_i(flush),
    .exmem_regwrite_i(exmem_we), .exmem_rd_i(exmem_rd),
    .memwb_regwrite_i(memwb_we), .memwb_rd_i(memwb_rd),
    .ex_valid_o(ex_valid2), .ex_rs1_data_o(ex_rs1_d2), .ex_rs2_data_o(ex_rs2_d2), .ex_imm_o(ex_imm2),
    .ex_rs1_addr_o(ex_rs1_a2), .ex_rs2_addr_o(ex_rs2_a2), .ex_rd_addr_o(ex_rd2), .ex_ctrl_o(ex_ctrl2),
    .fwd_a_sel_o(fwd_a2), .fwd_b_sel_o(fwd_b2), .load_use_stall_o(lus2), .bubble_cnt_o(cnt2)
  );

  typedef struct {
    logic        lus;
    logic [1:0]  fa, fb;
    logic        v;
    logic [31:0] d1, d2, imm;
    logic [4:0]  a1, a2, rd;
    logic [7:0]  ctrl;
    int          c16, c2;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: one architectural view of what EX currently holds.
  logic        m_v = 1'b0;
  logic [31:0] m_d1 = '0, m_d2 = '0, m_imm = '0;
  logic [4:0]  m_a1 = '0, m_a2 = '0, m_rd = '0;
  logic [7:0]  m_ctrl = '0;
  int          m_c16 = 0, m_c2 = 0;

  function automatic logic [1:0] fwd_ref(input logic v, input logic [4:0] rs);
    if (!v || rs == 5'd0) return 2'b00;
    if (exmem_we && exmem_rd == rs) return 2'b10;
    if (memwb_we && memwb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    logic haz, bub;
    haz = m_v && m_ctrl[CTRL_MEMREAD] && m_rd != 5'd0 && id_valid
          && (m_rd == rs1_a || m_rd == rs2_a);
    e.lus = haz && !flush;
    e.fa  = fwd_ref(m_v, m_a1);
    e.fb  = fwd_ref(m_v, m_a2);
    if (rst) begin
      {m_v, m_d1, m_d2, m_imm, m_a1, m_a2, m_rd, m_ctrl} = '0;
      m_c16 = 0; m_c2 = 0;
    end else if (!stall) begin
      bub = flush || haz || !id_valid;
      if (flush || haz) begin
        m_c16 = (m_c16 < 65535) ? m_c16 + 1 : 65535;
        m_c2  = (m_c2 < 3) ? m_c2 + 1 : 3;
      end
      if (bub) {m_v, m_d1, m_d2, m_imm, m_a1, m_a2, m_rd, m_ctrl} = '0;
      else begin
        m_v = 1'b1; m_d1 = rs1_d; m_d2 = rs2_d; m_imm = imm;
        m_a1 = rs1_a; m_a2 = rs2_a; m_rd = rd_a; m_ctrl = ctrl;
      end
    end
    e.v = m_v; e.d1 = m_d1; e.d2 = m_d2; e.imm = m_imm;
    e.a1 = m_a1; e.a2 = m_a2; e.rd = m_rd; e.ctrl = m_ctrl;
    e.c16 = m_c16; e.c2 = m_c2;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic rand_inputs();
    id_valid = ($urandom_range(0, 7) != 0);
    rs1_d = $urandom; rs2_d = $urandom; imm = $urandom;
    rs1_a = 5'($urandom_range(0, 7));
    rs2_a = 5'($urandom_range(0, 7));
    rd_a  = 5'($urandom_range(0, 7));
    ctrl  = 8'($urandom);
    stall = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 9) == 0);
    rst   = ($urandom_range(0, 99) == 0);
    exmem_we = $urandom_range(0, 1) == 1; exmem_rd = 5'($urandom_range(0, 7));
    memwb_we = $urandom_range(0, 1) == 1; memwb_rd = 5'($urandom_range(0, 7));
  endtask

  task automatic quiet();
    rst = 0; stall = 0; flush = 0; exmem_we = 0; memwb_we = 0;
    exmem_rd = 0; memwb_rd = 0; id_valid = 1;
  endtask

  task automatic load_lw7();
    rand_inputs(); quiet();
    rd_a = 5'd7; rs1_a = 5'd1; rs2_a = 5'd2;
    ctrl = 8'h0;
    ctrl[CTRL_MEMREAD] = 1'b1; ctrl[CTRL_REGWRITE] = 1'b1;
    step();
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs after the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("load_use_stall", 32'(lus), 32'(e.lus));
        chk("fwd_a", 32'(fwd_a), 32'(e.fa));
        chk("fwd_b", 32'(fwd_b), 32'(e.fb));
        chk("load_use_stall_w2", 32'(lus2), 32'(e.lus));
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(e.v));
        chk("ex_rs1_data", ex_rs1_d, e.d1);
        chk("ex_rs2_data", ex_rs2_d, e.d2);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_rs1_addr", 32'(ex_rs1_a), 32'(e.a1));
        chk("ex_rs2_addr", 32'(ex_rs2_a), 32'(e.a2));
        chk("ex_rd_addr", 32'(ex_rd), 32'(e.rd));
        chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
        chk("bubble_cnt", 32'(cnt16), 32'(e.c16));
        chk("bubble_cnt_w2", 32'(cnt2), 32'(e.c2));
        chk("ex_valid_w2", 32'(ex_valid2), 32'(e.v));
      end
    end
  end

  initial begin
    rand_inputs();
    rst = 1'b1;
    @(posedge clk);
    #2;
    // Reset held with ID inputs toggling.
    repeat (2) begin rand_inputs(); rst = 1'b1; step(); end

    // Forwarding priority on operand A.
    rand_inputs(); quiet(); rs1_a = 5'd5; rs2_a = 5'd3; rd_a = 5'd9; ctrl = 8'h01; step();
    exmem_we = 1; exmem_rd = 5'd5; memwb_we = 1; memwb_rd = 5'd5; step();
    exmem_rd = 5'd6; step();
    exmem_rd = 5'd0; memwb_rd = 5'd0; step();

    // Load-use: lw x7 then add using x7 as rs2.
    load_lw7();
    rand_inputs(); quiet(); rs1_a = 5'd3; rs2_a = 5'd7; rd_a = 5'd8; ctrl = 8'h01;
    step();
    step();
    memwb_we = 1; memwb_rd = 5'd7; step();

    // Stall for three cycles with changing ID inputs.
    for (int unsigned i = 0; i < 3; i++) begin
      rand_inputs(); rst = 0; flush = 0; stall = 1; step();
    end

    // Flush coinciding with a load-use hazard.
    load_lw7();
    rand_inputs(); quiet(); rs1_a = 5'd7; flush = 1; step();

    // Five load-use bubbles drive the narrow counter into saturation.
    for (int unsigned i = 0; i < 5; i++) begin
      load_lw7();
      rand_inputs(); quiet(); rs1_a = 5'd7; step();
    end

    for (int unsigned i = 0; i < 400; i++) begin
      rand_inputs();
      if ($urandom_range(0, 1) == 1) ctrl[CTRL_MEMREAD] = 1'b1;
      step();
    end

    quiet();
    for (int unsigned i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
